// File: rtl/seq1010_tx.sv
// seq1010_tx: serializes words MSB-first onto w_o and runs a reference 1010 Mealy detector on the stream
module seq1010_tx #(
  parameter int   WIDTH    = 8,
  parameter int   CNT_W    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             w_o,
  output logic             w_valid_o,
  output logic             busy_o,
  output logic             z_exp_o,
  output logic [CNT_W-1:0] match_cnt_o
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0, SHIFT = 1'b1;
  localparam logic [1:0] S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3;
  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [1:0]       model, model_nx;
  logic             last, accept;
  assign last        = state == SHIFT && bit_cnt == BW'(WIDTH - 1);
  assign ready_o     = rstn && (state == IDLE || last);
  assign accept      = valid_i && ready_o;
  assign w_o         = state == SHIFT ? shreg[WIDTH-1] : IDLE_BIT;
  assign w_valid_o   = state == SHIFT;
  assign busy_o      = state == SHIFT;
  assign z_exp_o     = model == S3 && !w_o;
  // Model also steps on idle bits, so idle gaps break a pattern in progress
  always_comb
    model_nx = w_o ? (model == S2 ? S3 : S1) : (model == S1 || model == S3 ? S2 : S0);
  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      model       <= S0;
      match_cnt_o <= '0;
    end else begin
      model <= model_nx;
      if (z_exp_o && !(&match_cnt_o)) match_cnt_o <= match_cnt_o + 1'b1;
      if (accept) begin
        state   <= SHIFT;
        shreg   <= data_i;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        state   <= last ? IDLE : SHIFT;
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq1010_tx.sv
// tb_seq1010_tx: directed and random stimulus scored against a bit-queue / pattern-history model
module tb_seq1010_tx;
  logic       clk_i = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, w, w_valid, busy, z;
  logic [7:0] cnt;
  logic       s_ready, s_w, s_w_valid, s_busy, s_z;
  logic [1:0] s_cnt;
  int n_tests = 0, n_fail = 0;
  bit q[$];
  logic [2:0] hist;
  int hn, cnt8, cnt2;
  logic acc;

  always #5 clk_i = ~clk_i;

  seq1010_tx #(.WIDTH(8), .CNT_W(8), .IDLE_BIT(1'b0)) dut (
    .clk_i(clk_i), .rstn(rstn), .data_i(data), .valid_i(valid), .ready_o(ready),
    .w_o(w), .w_valid_o(w_valid), .busy_o(busy), .z_exp_o(z), .match_cnt_o(cnt));

  seq1010_tx #(.WIDTH(8), .CNT_W(2), .IDLE_BIT(1'b0)) dut_s (
    .clk_i(clk_i), .rstn(rstn), .data_i(data), .valid_i(valid), .ready_o(s_ready),
    .w_o(s_w), .w_valid_o(s_w_valid), .busy_o(s_busy), .z_exp_o(s_z), .match_cnt_o(s_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs already driven at the negedge; check, clock, update model
  task automatic cyc();
    logic ew, ez, erdy;
    #1;
    ew   = q.size() > 0 ? q[0] : 1'b0;
    ez   = hn == 3 && hist == 3'b101 && !ew;
    erdy = rstn && q.size() <= 1;
    chk("w", w, ew);
    chk("w_valid", w_valid, q.size() > 0);
    chk("busy", busy, q.size() > 0);
    chk("ready", ready, erdy);
    chk("z", z, ez);
    chk("cnt", cnt, cnt8);
    chk("cnt_sat", s_cnt, cnt2);
    acc = valid && erdy;
    @(posedge clk_i);
    if (!rstn) begin
      q.delete();
      hist = 3'b000;
      hn = 0;
      cnt8 = 0;
      cnt2 = 0;
    end else begin
      if (ez && cnt8 != 255) cnt8++;
      if (ez && cnt2 != 3) cnt2++;
      hist = {hist[1:0], ew};
      hn = hn < 3 ? hn + 1 : 3;
      if (q.size() > 0) void'(q.pop_front());
      if (acc) for (int i = 7; i >= 0; i--) q.push_back(data[i]);
    end
    @(negedge clk_i);
    if (acc) valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, output int n);
    valid = 1'b1;
    data = d;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc && n < 40);
    if (!acc) begin
      chk("send_timeout", n, 0);
      valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) cyc();
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    @(negedge clk_i);
    do_reset(2);
    chk("rst_w", w, 0);
    chk("rst_wv", w_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_z", z, 0);
    chk("rst_cnt", cnt, 0);
    // 1: single word A0
    send(8'hA0, n);
    repeat (12) cyc();
    chk("t1_cnt", cnt, 1);
    // 2: overlapping matches in AA, trailing idle adds none
    do_reset(1);
    send(8'hAA, n);
    repeat (12) cyc();
    chk("t2_cnt", cnt, 3);
    // 3: back-to-back 0A then A0
    do_reset(1);
    send(8'h0A, n);
    send(8'hA0, n);
    chk("t3_wait", n, 8);
    repeat (12) cyc();
    chk("t3_cnt", cnt, 3);
    // 4: backpressure, 55 offered during bit 2 of FF
    do_reset(1);
    send(8'hFF, n);
    cyc();
    send(8'h55, n);
    chk("t4_wait", n, 7);
    chk("t4_msb", w, 0);
    chk("t4_wv", w_valid, 1);
    repeat (12) cyc();
    chk("t4_cnt", cnt, 4);
    // 5: reset mid-word
    do_reset(1);
    send(8'hAA, n);
    repeat (2) cyc();
    do_reset(2);
    chk("t5_w", w, 0);
    chk("t5_wv", w_valid, 0);
    chk("t5_cnt", cnt, 0);
    send(8'hA0, n);
    repeat (12) cyc();
    chk("t5_cnt2", cnt, 1);
    // 6: saturation on the CNT_W=2 instance
    do_reset(1);
    send(8'hAA, n);
    send(8'hAA, n);
    repeat (20) cyc();
    chk("t6_cnt", cnt, 7);
    chk("t6_sat", s_cnt, 3);
    // random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      rstn = ($urandom % 60) != 0;
      if (!valid && ($urandom % 3) == 0) begin
        valid = 1'b1;
        data = 8'($urandom);
      end
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq1010_tx.md
Name: seq1010_tx

Overview:
- Serial stimulus transmitter that drives the `w` input of the 1010 overlapping Mealy sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- Runs an internal reference model of the 1010 detector on the emitted stream. It produces the expected `z` each cycle and a saturating match count, so a bench can scoreboard the detector directly.

Parameters:
- WIDTH, 8, payload word width in bits; must be >= 2.
- CNT_W, 8, width of the match counter.
- IDLE_BIT, 1'b0, value driven on w_o when no payload bit is being sent.

Ports:
- clk_i  input  1  single clock; all logic on posedge.
- rstn  input  1  reset, synchronous, active-low.
- data_i  input  WIDTH  word to serialize.
- valid_i  input  1  data_i valid.
- ready_o  output  1  block can accept a word this cycle.
- w_o  output  1  serial bit stream, registered; connects to detector w.
- w_valid_o  output  1  high when w_o carries a payload bit.
- busy_o  output  1  high while in SHIFT.
- z_exp_o  output  1  expected detector output for the current w_o (Mealy, combinational from model state and w_o).
- match_cnt_o  output  CNT_W  number of cycles z_exp_o was high since reset; saturating.

Behaviour:
- Reset (rstn=0 sampled at posedge):
  - state<=IDLE, shreg<=0, bit_cnt<=0, model<=S0, match_cnt<=0.
  - ready_o is forced 0 while rstn=0.
  - After reset: w_o=IDLE_BIT, w_valid_o=0, busy_o=0, z_exp_o=(model==S3)&~w_o=0.
- Transfer FSM, states IDLE and SHIFT:
  - IDLE: ready_o=1. On valid_i&ready_o: shreg<=data_i, bit_cnt<=0, ->SHIFT.
  - SHIFT: w_o=shreg[WIDTH-1], w_valid_o=1, busy_o=1. Each clock: shreg<=shreg<<1, bit_cnt<=bit_cnt+1.
  - SHIFT, bit_cnt==WIDTH-1 (last bit): ready_o=1.
    - If valid_i, load the new word and stay in SHIFT with bit_cnt<=0. No gap bit; back-to-back words form a continuous stream.
    - Otherwise go to IDLE.
  - SHIFT, any other bit_cnt: ready_o=0.
  - In IDLE: w_o=IDLE_BIT, w_valid_o=0.
- Latency: word accepted at edge k -> MSB on w_o during cycle k+1; LSB during cycle k+WIDTH.
- Handshake rules:
  - Source must hold valid_i and data_i stable until accepted.
  - valid_i is ignored while ready_o=0.
  - There is no abort.
- Reference model (2-bit state S0..S3), advanced every clock on the current w_o, including idle bits:
  - S0: w ? S1 : S0.
  - S1: w ? S1 : S2.
  - S2: w ? S3 : S0.
  - S3: w ? S1 : S2.
  - z_exp_o=(model==S3)&(w_o==0).
- Counter: match_cnt<=match_cnt+1 when z_exp_o=1 and match_cnt != all-ones; holds at all-ones.
- Reset mid-word: the word in flight is discarded. The next cycle shows idle outputs and model=S0, and the count clears.
- Pattern spanning words: matches that straddle a back-to-back word boundary are counted. A pattern broken by idle bits is not counted.

Test Plan (WIDTH=8, IDLE_BIT=0 unless stated):
1. Reset, then send 8'hA0 -> w_o=1,0,1,0,0,0,0,0 on cycles k+1..k+8; z_exp_o high only at k+4; match_cnt_o=1; w_valid_o high for exactly 8 cycles; ready_o=1 at k+8.
2. Overlap: send 8'hAA -> z_exp_o high at bits 4, 6 and 8; match_cnt_o=3; no extra match on the trailing idle 0 (model S2->S0).
3. Back-to-back: hold valid_i with 8'h0A, then 8'hA0 accepted on the last-bit cycle -> 16 contiguous w_valid_o cycles; z_exp_o at stream bits 8, 10 and 12; match_cnt_o=3.
4. Backpressure: assert valid_i with 8'h55 during bit 2 of an 8'hFF transfer -> ready_o stays 0 until the last-bit cycle, then the word is accepted; 8'h55 MSB appears on the next cycle.
5. Reset mid-word: send 8'hAA, drive rstn=0 at bit 3 for 2 cycles -> ready_o=0 during reset; after release w_o=0, w_valid_o=0, match_cnt_o=0; a fresh 8'hA0 then gives match_cnt_o=1.
6. Saturation: CNT_W=2, 8'hAA twice back-to-back (7 matches) -> match_cnt_o=1,2,3 then holds at 3.
